// File: rtl/intr_pkg.sv
// intr_pkg: FSM encoding and FIFO entry layout for the kernel interrupt arbiter.
package intr_pkg;
    localparam int IDXW = 3;
    localparam int SRCW = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
    function automatic int entry_w(input int ctxw);
        return IDXW + SRCW + ctxw;
    endfunction
endpackage

// File: rtl/intr_fifo.sv
// intr_fifo: queue of granted interrupts; pointers carry one extra wrap bit.
module intr_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 76
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] r_wptr, r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic w_push, w_pop;
    assign w_push = i_push && !o_full;
    assign w_pop = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout = r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/kernel_intr_arbiter.sv
// kernel_intr_arbiter: latches per-kernel interrupt pulses, merges them round-robin
// into a FIFO and hands them to the host one at a time with a req/ack handshake.
module kernel_intr_arbiter
    import intr_pkg::*;
#(
    parameter int NUM_KERNELS = 4,
    parameter int CTXW = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KERNELS-1:0]      kern_intr_req,
    input  logic [NUM_KERNELS*64-1:0]   kern_intr_src,
    input  logic [NUM_KERNELS*CTXW-1:0] kern_intr_ctx,
    output logic [NUM_KERNELS-1:0]      kern_intr_ack,
    output logic                        intr_req,
    output logic [63:0]                 intr_src,
    output logic [CTXW-1:0]             intr_ctx,
    input  logic                        intr_ack,
    output logic [NUM_KERNELS-1:0]      intr_pending,
    output logic                        err_overrun
);
    localparam int EW = entry_w(CTXW);
    state_t r_state, w_state_nxt;
    logic [NUM_KERNELS-1:0] r_pending, r_queued, r_kack, w_set, w_clr, w_cand, w_gnt_oh;
    logic [SRCW-1:0] r_src [NUM_KERNELS];
    logic [CTXW-1:0] r_ctx [NUM_KERNELS];
    logic [IDXW-1:0] r_rr, w_gnt_idx, w_head_idx;
    logic w_gnt_vld, w_full, w_empty, w_pop, r_err;
    logic [EW-1:0] w_gnt_data, w_head;

    assign w_set = kern_intr_req & ~r_pending;
    assign w_cand = r_pending & ~r_queued;
    assign w_pop = (r_state == WAIT_ACK) && intr_ack;
    assign w_head_idx = w_head[EW-1 -: IDXW];
    assign intr_src = w_head[CTXW +: SRCW];
    assign intr_ctx = w_head[CTXW-1:0];
    assign kern_intr_ack = r_kack;
    assign intr_pending = r_pending;
    assign err_overrun = r_err;

    // Round-robin: scan from r_rr, first captured-but-unqueued kernel wins.
    always_comb begin
        int j;
        j = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            j = int'(r_rr) + i;
            if (j >= NUM_KERNELS) j = j - NUM_KERNELS;
            if (!w_full && !w_gnt_vld && w_cand[j]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDXW'(j);
                w_gnt_oh[j] = 1'b1;
                w_gnt_data = {IDXW'(j), r_src[j], r_ctx[j]};
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_KERNELS; i++) w_clr[i] = w_pop && (w_head_idx == IDXW'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_queued <= '0;
            r_kack <= '0;
            r_rr <= '0;
            r_err <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_queued <= (r_queued & ~w_clr) | w_gnt_oh;
            r_kack <= w_clr;
            r_err <= r_err | (|(kern_intr_req & r_pending));
            if (w_gnt_vld) r_rr <= (w_gnt_idx == IDXW'(NUM_KERNELS-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (w_set[i]) begin
                r_src[i] <= kern_intr_src[64*i +: 64];
                r_ctx[i] <= kern_intr_ctx[CTXW*i +: CTXW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        intr_req = 1'b0;
        w_state_nxt = (r_state == IDLE && !w_empty) ? ISSUE :
                      (r_state == ISSUE) ? WAIT_ACK :
                      w_pop ? IDLE : r_state;
        intr_req = (r_state == ISSUE);
    end

    intr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_gnt_vld),
        .i_din   (w_gnt_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_kernel_intr_arbiter.sv
// tb_kernel_intr_arbiter: scenario tasks plus a scoreboard that checks every host
// interrupt against the expected source/context order.
module tb_kernel_intr_arbiter;
    localparam int NK = 4;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NK-1:0] kern_intr_req = '0;
    logic [NK*64-1:0] kern_intr_src = '0;
    logic [NK*CW-1:0] kern_intr_ctx = '0;
    logic [NK-1:0] kern_intr_ack;
    logic intr_req;
    logic [63:0] intr_src;
    logic [CW-1:0] intr_ctx;
    logic intr_ack = 1'b0;
    logic [NK-1:0] intr_pending;
    logic err_overrun;

    typedef struct {
        logic [63:0] src;
        logic [CW-1:0] ctx;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int kack_cnt [NK];

    kernel_intr_arbiter #(.NUM_KERNELS(NK), .CTXW(CW), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .kern_intr_req (kern_intr_req),
        .kern_intr_src (kern_intr_src),
        .kern_intr_ctx (kern_intr_ctx),
        .kern_intr_ack (kern_intr_ack),
        .intr_req      (intr_req),
        .intr_src      (intr_src),
        .intr_ctx      (intr_ctx),
        .intr_ack      (intr_ack),
        .intr_pending  (intr_pending),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) if (kern_intr_ack[k] === 1'b1) kack_cnt[k]++;
        if (intr_req === 1'b1) begin
            req_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected intr_req src=%h ctx=%h, none expected", intr_src, intr_ctx);
            end else begin
                mon_e = sb.pop_front();
                if (intr_src !== mon_e.src || intr_ctx !== mon_e.ctx) begin
                    errors++;
                    $display("FAIL issue: got src=%h ctx=%h want src=%h ctx=%h", intr_src, intr_ctx, mon_e.src, mon_e.ctx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_kack();
        for (int k = 0; k < NK; k++) kack_cnt[k] = 0;
    endtask

    task automatic fire(input logic [NK-1:0] mask, input logic [63:0] sbase, input logic [CW-1:0] cbase, input bit exp_on);
        @(posedge clk);
        #1;
        kern_intr_req = mask;
        for (int k = 0; k < NK; k++) begin
            kern_intr_src[64*k +: 64] = sbase + 64'(k);
            kern_intr_ctx[CW*k +: CW] = cbase + CW'(k);
            if (mask[k] && exp_on) sb.push_back('{sbase + 64'(k), cbase + CW'(k)});
        end
        @(posedge clk);
        #1;
        kern_intr_req = '0;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 intr_ack = 1'b1;
        @(posedge clk);
        #1 intr_ack = 1'b0;
    endtask

    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (intr_req !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (w >= 40) begin
                errors++;
                $display("FAIL serve: no intr_req within %0d cycles, want one", w);
            end
            ack_pulse();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL reset intr_req: got %b want 0", intr_req); end
        checks++; if (kern_intr_ack !== 4'b0) begin errors++; $display("FAIL reset kern_intr_ack: got %b want 0", kern_intr_ack); end
        checks++; if (intr_pending !== 4'b0) begin errors++; $display("FAIL reset intr_pending: got %b want 0", intr_pending); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset err_overrun: got %b want 0", err_overrun); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_single();
        clear_kack();
        fire(4'b0100, 64'h2, 9'h3, 1'b1);
        @(negedge clk);
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL single T+1 intr_req: got %b want 0", intr_req); end
        checks++; if (intr_pending !== 4'b0100) begin errors++; $display("FAIL single pending: got %b want 0100", intr_pending); end
        @(negedge clk);
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL single T+2 intr_req: got %b want 0", intr_req); end
        @(negedge clk);
        checks++; if (intr_req !== 1'b1 || intr_src !== 64'h4 || intr_ctx !== 9'h5) begin
            errors++; $display("FAIL single T+3: got req=%b src=%h ctx=%h want 1/4/5", intr_req, intr_src, intr_ctx);
        end
        @(negedge clk);
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL single T+4 intr_req: got %b want 0", intr_req); end
        @(negedge clk);
        @(posedge clk);
        #1 intr_ack = 1'b1;
        @(negedge clk);
        checks++; if (kern_intr_ack !== 4'b0) begin errors++; $display("FAIL single T+6 kack: got %b want 0000", kern_intr_ack); end
        @(posedge clk);
        #1 intr_ack = 1'b0;
        @(negedge clk);
        checks++; if (kern_intr_ack !== 4'b0100) begin errors++; $display("FAIL single T+7 kack: got %b want 0100", kern_intr_ack); end
        checks++; if (intr_pending !== 4'b0) begin errors++; $display("FAIL single T+7 pending: got %b want 0", intr_pending); end
        @(negedge clk);
        checks++; if (kern_intr_ack !== 4'b0) begin errors++; $display("FAIL single T+8 kack: got %b want 0000", kern_intr_ack); end
    endtask

    task automatic test_spurious_ack();
        clear_kack();
        ack_pulse();
        repeat (3) @(negedge clk);
        checks++; if (kack_cnt[0] + kack_cnt[1] + kack_cnt[2] + kack_cnt[3] != 0) begin
            errors++; $display("FAIL spurious idle kack: got %0d pulses want 0", kack_cnt[0] + kack_cnt[1] + kack_cnt[2] + kack_cnt[3]);
        end
        fire(4'b0010, 64'h10, 9'h11, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 intr_ack = 1'b1;
        @(posedge clk);
        #1 intr_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (kack_cnt[1] != 0) begin errors++; $display("FAIL spurious issue kack: got %0d want 0", kack_cnt[1]); end
        checks++; if (intr_pending !== 4'b0010) begin errors++; $display("FAIL spurious pending: got %b want 0010", intr_pending); end
        ack_pulse();
        @(negedge clk);
        checks++; if (kern_intr_ack !== 4'b0010) begin errors++; $display("FAIL spurious real ack: got %b want 0010", kern_intr_ack); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = req_cnt;
        clear_kack();
        fire(4'b0001, 64'h300, 9'h60, 1'b1);
        serve(1);
        checks++; if (kern_intr_ack !== 4'b0001) begin errors++; $display("FAIL b2b kack window: got %b want 0001", kern_intr_ack); end
        kern_intr_req = 4'b0001;
        kern_intr_src[63:0] = 64'h333;
        kern_intr_ctx[CW-1:0] = 9'h66;
        sb.push_back('{64'h333, 9'h66});
        @(posedge clk);
        #1 kern_intr_req = '0;
        serve(1);
        repeat (4) @(negedge clk);
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL b2b err_overrun: got %b want 0", err_overrun); end
        checks++; if (kack_cnt[0] != 2) begin errors++; $display("FAIL b2b kack count: got %0d want 2", kack_cnt[0]); end
        checks++; if (req_cnt - base != 2) begin errors++; $display("FAIL b2b issues: got %0d want 2", req_cnt - base); end
    endtask

    task automatic test_simultaneous();
        int base;
        apply_reset();
        base = req_cnt;
        clear_kack();
        fire(4'hF, 64'h100, 9'h20, 1'b1);
        serve(4);
        repeat (4) @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL simul left: got %0d want 0", sb.size()); end
        checks++; if (req_cnt - base != 4) begin errors++; $display("FAIL simul issues: got %0d want 4", req_cnt - base); end
        for (int k = 0; k < NK; k++) begin
            checks++; if (kack_cnt[k] != 1) begin errors++; $display("FAIL simul kack[%0d]: got %0d want 1", k, kack_cnt[k]); end
        end
    endtask

    task automatic test_fifo_full();
        int base;
        logic [1:0] occ;
        base = req_cnt;
        clear_kack();
        fire(4'hF, 64'h200, 9'h40, 1'b1);
        repeat (10) @(negedge clk);
        occ = dut.u_fifo.r_wptr - dut.u_fifo.r_rptr;
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL full occupancy: got %0d want 2", occ); end
        checks++; if (intr_pending !== 4'hF) begin errors++; $display("FAIL full pending: got %b want 1111", intr_pending); end
        checks++; if (req_cnt - base != 1) begin errors++; $display("FAIL full issues held: got %0d want 1", req_cnt - base); end
        ack_pulse();
        serve(3);
        repeat (6) @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full left: got %0d want 0", sb.size()); end
        checks++; if (req_cnt - base != 4) begin errors++; $display("FAIL full issues: got %0d want 4", req_cnt - base); end
        checks++; if (intr_pending !== 4'b0) begin errors++; $display("FAIL full pending end: got %b want 0", intr_pending); end
        for (int k = 0; k < NK; k++) begin
            checks++; if (kack_cnt[k] != 1) begin errors++; $display("FAIL full kack[%0d]: got %0d want 1", k, kack_cnt[k]); end
        end
    endtask

    task automatic test_overrun();
        int base;
        base = req_cnt;
        clear_kack();
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun pre: got %b want 0", err_overrun); end
        fire(4'b0010, 64'h400, 9'h50, 1'b1);
        fire(4'b0010, 64'h4F0, 9'h5F, 1'b0);
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun flag: got %b want 1", err_overrun); end
        serve(1);
        repeat (8) @(negedge clk);
        checks++; if (req_cnt - base != 1) begin errors++; $display("FAIL overrun issues: got %0d want 1", req_cnt - base); end
        checks++; if (kack_cnt[1] != 1) begin errors++; $display("FAIL overrun kack: got %0d want 1", kack_cnt[1]); end
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b want 1", err_overrun); end
    endtask

    task automatic test_reset_mid();
        int base;
        int w;
        w = 0;
        fire(4'b1000, 64'h500, 9'h70, 1'b1);
        @(negedge clk);
        while (intr_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++; if (w >= 20) begin errors++; $display("FAIL rstmid issue: no intr_req in %0d cycles", w); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL rstmid intr_req: got %b want 0", intr_req); end
        checks++; if (intr_pending !== 4'b0) begin errors++; $display("FAIL rstmid pending: got %b want 0", intr_pending); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL rstmid err_overrun: got %b want 0", err_overrun); end
        checks++; if (kern_intr_ack !== 4'b0) begin errors++; $display("FAIL rstmid kack: got %b want 0", kern_intr_ack); end
        sb.delete();
        clear_kack();
        base = req_cnt;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (kack_cnt[0] + kack_cnt[1] + kack_cnt[2] + kack_cnt[3] != 0 || req_cnt != base) begin
            errors++; $display("FAIL rstmid leftover: got kack=%0d issues=%0d want 0/0", kack_cnt[0] + kack_cnt[1] + kack_cnt[2] + kack_cnt[3], req_cnt - base);
        end
        fire(4'b0100, 64'h600, 9'h80, 1'b1);
        @(negedge clk);
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL rstmid T+1 intr_req: got %b want 0", intr_req); end
        @(negedge clk);
        checks++; if (intr_req !== 1'b0) begin errors++; $display("FAIL rstmid T+2 intr_req: got %b want 0", intr_req); end
        @(negedge clk);
        checks++; if (intr_req !== 1'b1) begin errors++; $display("FAIL rstmid T+3 intr_req: got %b want 1", intr_req); end
        ack_pulse();
        @(negedge clk);
        checks++; if (kern_intr_ack !== 4'b0100) begin errors++; $display("FAIL rstmid kack after: got %b want 0100", kern_intr_ack); end
    endtask

    initial begin
        clear_kack();
        test_reset();
        test_single();
        test_spurious_ack();
        test_back_to_back();
        test_simultaneous();
        test_fifo_full();
        test_overrun();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL final scoreboard: got %0d left want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
